vend_lane_ctrl: RTL and testbench
=================================

// Module: vend_lane_ctrl
// PURPOSE
//  Vending controller that sequences a 4-lane dispense mechanism and a half-dollar change hopper.
//  Keeps a credit register from coin pulses and checks a product selection against a per-lane price.
//  Then drives the lane motor, pays change one half-dollar at a time and refunds on cancel or jam.
//  Sits between the coin acceptor / keypad front end and the motor and hopper drivers.
// PARAMETERS
//  PRICE0       3    lane 0 price, in half-dollar units
//  PRICE1       4    lane 1 price, in half-dollar units
//  PRICE2       5    lane 2 price, in half-dollar units
//  PRICE3       6    lane 3 price, in half-dollar units
//  MAX_CREDIT   10   credit ceiling, in half-dollar units (<=15)
//  MOTOR_TMO    255  max cycles in DISPENSE before a jam is declared
//  CHANGE_GAP   4    cycles between half_out pulses (>=2)
// PORTS
//  clk          in   1  clock, rising edge
//  reset        in   1  synchronous reset, active high
//  half_dollar  in   1  1-cycle pulse: 50c coin inserted
//  one_dollar   in   1  1-cycle pulse: $1 coin inserted
//  sel_valid    in   1  1-cycle pulse: product selected
//  sel          in   2  lane number, qualified by sel_valid
//  cancel       in   1  1-cycle pulse: refund request
//  motor_done   in   1  mechanism reports item dropped
//  coin_reject  out  1  1-cycle pulse: coin(s) of this cycle returned unaccepted
//  no_funds     out  1  1-cycle pulse: selection refused, credit < price
//  collect      out  1  1-cycle pulse: price committed (coins to cash box)
//  motor_on     out  1  level: lane motor energised
//  motor_lane   out  2  lane being driven, valid while motor_on
//  dispense     out  1  1-cycle pulse: item delivered
//  jam          out  1  1-cycle pulse: motor timeout, price refunded
//  half_out     out  1  1-cycle pulse: hopper ejects one 50c coin
//  credit       out  4  current credit, in half-dollar units
//  busy         out  1  state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, credit=0, timers=0, all outputs 0.
//   Reset mid-operation abandons the vend and any refund (no payout).
//  States: IDLE, DISPENSE, CHANGE. Registered outputs; pulses appear the cycle after the cause.
//  IDLE, priority cancel > sel_valid > coins:
//   - cancel, credit>0: go to CHANGE (full refund). cancel with credit=0 is ignored.
//   - sel_valid, credit>=PRICE[sel]: credit-=price; latch lane; collect=1; go to DISPENSE.
//   - sel_valid, credit<PRICE[sel]: no_funds=1; stay in IDLE.
//   - Coins: add = half_dollar + 2*one_dollar (both in one cycle -> +3).
//   - Coins are added only when neither cancel nor an accepted select occurs that cycle.
//   - Coins are added only if credit+add <= MAX_CREDIT; otherwise all coins of that cycle are rejected.
//   - A refused selection (no_funds) still allows that cycle's coins to be added.
//  Coins arriving in DISPENSE or CHANGE: coin_reject=1, credit unchanged.
//  sel_valid and cancel are ignored outside IDLE.
//  DISPENSE:
//   - motor_on=1, motor_lane=latched lane; cycle timer counts from 0.
//   - motor_done: motor_on=0, dispense=1; go to CHANGE if credit>0, else to IDLE.
//   - Timer reaches MOTOR_TMO without motor_done: motor_on=0, jam=1,
//     credit+=latched price, go to CHANGE.
//   - motor_done in the same cycle as the timeout: treated as success.
//  CHANGE:
//   - First half_out pulse comes 1 cycle after entry, then one every CHANGE_GAP cycles.
//   - credit decrements by 1 on each pulse. When credit reaches 0, go to IDLE.
//   - Number of half_out pulses always equals credit on entry.
//  Credit never exceeds MAX_CREDIT and never underflows.
//   - Refund after a jam cannot overflow (credit+price <= MAX_CREDIT was true before the vend).
// STRUCTURE
//  Shared package vend_pkg: state encoding, CREDIT_W=4, LANE_W=2, lane price table type.
//  One sub-module, vend_change_pacer:
//   - gap counter that issues half_out pulses while enabled.
//   - reports done when the count reaches zero.
//  Top level: FSM, credit register, motor timeout counter.
// TESTING
//  1. Reset then half+one+half (credit 4), sel=1 -> collect, motor_on lane 1; motor_done -> dispense; credit 0 -> IDLE, no half_out.
//  2. Credit 6, sel=0 (price 3) -> dispense, then exactly 3 half_out pulses spaced 4 cycles; credit 0; busy falls.
//  3. Credit 9, one_dollar -> coin_reject, credit stays 9. Credit 2, sel=3 -> no_funds, credit 2.
//  4. Credit 5, sel=2, hold motor_done=0 -> jam at 255 cycles; credit 5 restored; 5 half_out pulses.
//  5. Coin during DISPENSE -> coin_reject. cancel+sel_valid together with credit 4 -> refund of 4, no collect.
//  6. reset asserted during CHANGE with 3 half-dollars left -> all outputs 0 next cycle, credit 0, no further half_out.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and widths for the vending lane controller.
package vend_pkg;

  localparam int unsigned CREDIT_W = 4;
  localparam int unsigned LANE_W   = 2;
  localparam int unsigned NUM_LANE = 4;
  localparam int unsigned TMR_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_CHANGE   = 2'd2
  } state_e;

  typedef logic [NUM_LANE-1:0][CREDIT_W-1:0] price_tbl_t;

  function automatic logic [CREDIT_W-1:0] lane_price(input price_tbl_t tbl,
                                                     input logic [LANE_W-1:0] lane);
    return tbl[lane];
  endfunction

endpackage

// File: rtl/vend_change_pacer.sv
// Paces half-dollar payouts: fires on the first enabled cycle after load, then every CHANGE_GAP cycles.
module vend_change_pacer
  import vend_pkg::*;
#(
  parameter int unsigned CHANGE_GAP = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_load,
  input  logic                i_en,
  input  logic [CREDIT_W-1:0] i_count,
  output logic                o_fire_c,
  output logic                o_done_c
);

  localparam int unsigned GAP_W = $clog2(CHANGE_GAP);

  logic [GAP_W-1:0] r_gap;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_gap <= '0;
    end else if (i_load) begin
      r_gap <= '0;
    end else if (i_en) begin
      if (r_gap == '0) r_gap <= GAP_W'(CHANGE_GAP - 1);
      else             r_gap <= r_gap - GAP_W'(1);
    end
  end

  assign o_fire_c = i_en && (r_gap == '0);
  // The last coin is the one paid while a single unit remains.
  assign o_done_c = o_fire_c && (i_count == CREDIT_W'(1));

endmodule

// File: rtl/vend_lane_ctrl.sv
// Vending controller: credit accounting, lane motor sequencing with jam timeout, and change payout.
module vend_lane_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE0     = 3,
  parameter int unsigned PRICE1     = 4,
  parameter int unsigned PRICE2     = 5,
  parameter int unsigned PRICE3     = 6,
  parameter int unsigned MAX_CREDIT = 10,
  parameter int unsigned MOTOR_TMO  = 255,
  parameter int unsigned CHANGE_GAP = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_half_dollar,
  input  logic                i_one_dollar,
  input  logic                i_sel_valid,
  input  logic [LANE_W-1:0]   i_sel,
  input  logic                i_cancel,
  input  logic                i_motor_done,
  output logic                o_coin_reject,
  output logic                o_no_funds,
  output logic                o_collect,
  output logic                o_motor_on,
  output logic [LANE_W-1:0]   o_motor_lane,
  output logic                o_dispense,
  output logic                o_jam,
  output logic                o_half_out,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_busy
);

  localparam int unsigned SUM_W = CREDIT_W + 1;
  localparam price_tbl_t PRICES = {CREDIT_W'(PRICE3), CREDIT_W'(PRICE2),
                                   CREDIT_W'(PRICE1), CREDIT_W'(PRICE0)};

  state_e              r_state, w_nx_state;
  logic [CREDIT_W-1:0] r_credit, w_nx_credit;
  logic [LANE_W-1:0]   r_lane, w_nx_lane;
  logic [TMR_W-1:0]    r_timer, w_nx_timer;
  logic r_coin_reject, r_no_funds, r_collect, r_motor_on, r_dispense, r_jam, r_half_out, r_busy;
  logic w_coin_reject, w_no_funds, w_collect, w_dispense, w_jam, w_half_out;
  logic w_load, w_fire, w_done, w_in_change, w_coin;
  logic [SUM_W-1:0]    w_sum;
  logic [CREDIT_W-1:0] w_sel_price;

  assign w_in_change = (r_state == ST_CHANGE);
  assign w_coin      = i_half_dollar | i_one_dollar;
  // {one, half} read as a 2-bit number is exactly half + 2*one.
  assign w_sum       = {1'b0, r_credit} + SUM_W'({i_one_dollar, i_half_dollar});
  assign w_sel_price = lane_price(PRICES, i_sel);

  vend_change_pacer #(
    .CHANGE_GAP (CHANGE_GAP)
  ) u_pacer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (w_load),
    .i_en     (w_in_change),
    .i_count  (r_credit),
    .o_fire_c (w_fire),
    .o_done_c (w_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_credit      <= '0;
      r_lane        <= '0;
      r_timer       <= '0;
      r_coin_reject <= 1'b0;
      r_no_funds    <= 1'b0;
      r_collect     <= 1'b0;
      r_motor_on    <= 1'b0;
      r_dispense    <= 1'b0;
      r_jam         <= 1'b0;
      r_half_out    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_nx_state;
      r_credit      <= w_nx_credit;
      r_lane        <= w_nx_lane;
      r_timer       <= w_nx_timer;
      r_coin_reject <= w_coin_reject;
      r_no_funds    <= w_no_funds;
      r_collect     <= w_collect;
      r_motor_on    <= (w_nx_state == ST_DISPENSE);
      r_dispense    <= w_dispense;
      r_jam         <= w_jam;
      r_half_out    <= w_half_out;
      r_busy        <= (w_nx_state != ST_IDLE);
    end
  end

  // Next-state, credit and pulse decode.
  always_comb begin
    w_nx_state    = r_state;
    w_nx_credit   = r_credit;
    w_nx_lane     = r_lane;
    w_nx_timer    = r_timer;
    w_coin_reject = 1'b0;
    w_no_funds    = 1'b0;
    w_collect     = 1'b0;
    w_dispense    = 1'b0;
    w_jam         = 1'b0;
    w_half_out    = 1'b0;
    w_load        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cancel && (r_credit != '0)) begin
          w_nx_state    = ST_CHANGE;
          w_load        = 1'b1;
          w_coin_reject = w_coin;
        end else if (i_sel_valid && (r_credit >= w_sel_price)) begin
          w_nx_credit   = r_credit - w_sel_price;
          w_nx_lane     = i_sel;
          w_nx_timer    = '0;
          w_collect     = 1'b1;
          w_nx_state    = ST_DISPENSE;
          w_coin_reject = w_coin;
        end else begin
          w_no_funds = i_sel_valid;
          if (w_coin) begin
            if (w_sum <= SUM_W'(MAX_CREDIT)) w_nx_credit   = w_sum[CREDIT_W-1:0];
            else                             w_coin_reject = 1'b1;
          end
        end
      end
      ST_DISPENSE: begin
        w_coin_reject = w_coin;
        if (i_motor_done) begin
          w_dispense = 1'b1;
          w_nx_lane  = '0;
          if (r_credit != '0) begin
            w_nx_state = ST_CHANGE;
            w_load     = 1'b1;
          end else begin
            w_nx_state = ST_IDLE;
          end
        end else if (r_timer == TMR_W'(MOTOR_TMO - 1)) begin
          w_jam       = 1'b1;
          w_nx_credit = r_credit + lane_price(PRICES, r_lane);
          w_nx_lane   = '0;
          w_nx_state  = ST_CHANGE;
          w_load      = 1'b1;
        end else begin
          w_nx_timer = r_timer + TMR_W'(1);
        end
      end
      ST_CHANGE: begin
        w_coin_reject = w_coin;
        if (w_fire) begin
          w_half_out  = 1'b1;
          w_nx_credit = r_credit - CREDIT_W'(1);
          if (w_done) w_nx_state = ST_IDLE;
        end
      end
      default: w_nx_state = ST_IDLE;
    endcase
  end

  assign o_coin_reject = r_coin_reject;
  assign o_no_funds    = r_no_funds;
  assign o_collect     = r_collect;
  assign o_motor_on    = r_motor_on;
  assign o_motor_lane  = r_lane;
  assign o_dispense    = r_dispense;
  assign o_jam         = r_jam;
  assign o_half_out    = r_half_out;
  assign o_credit      = r_credit;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_vend_lane_ctrl.sv
// Directed self-checking bench for vend_lane_ctrl.
module tb_vend_lane_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       half_dollar = 1'b0, one_dollar = 1'b0, sel_valid = 1'b0, cancel = 1'b0, motor_done = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       coin_reject, no_funds, collect, motor_on, dispense, jam, half_out, busy;
  logic [1:0] motor_lane;
  logic [3:0] credit;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vend_lane_ctrl dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_half_dollar (half_dollar),
    .i_one_dollar  (one_dollar),
    .i_sel_valid   (sel_valid),
    .i_sel         (sel),
    .i_cancel      (cancel),
    .i_motor_done  (motor_done),
    .o_coin_reject (coin_reject),
    .o_no_funds    (no_funds),
    .o_collect     (collect),
    .o_motor_on    (motor_on),
    .o_motor_lane  (motor_lane),
    .o_dispense    (dispense),
    .o_jam         (jam),
    .o_half_out    (half_out),
    .o_credit      (credit),
    .o_busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    half_dollar = 0; one_dollar = 0; sel_valid = 0; cancel = 0; motor_done = 0;
  endtask

  task automatic coin(input logic h, input logic o);
    half_dollar = h; one_dollar = o;
    tick();
    clear_inputs();
  endtask

  // Runs until busy drops (bounded), counting half_out pulses and the tick index of each.
  task automatic drain(input int bound, output int n, output int first_at,
                       output int max_gap, output int min_gap, output bit timed_out);
    int last;
    n = 0; first_at = -1; max_gap = 0; min_gap = 1000; last = 0; timed_out = 1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (half_out) begin
        if (n == 0) first_at = i;
        else begin
          if (i - last > max_gap) max_gap = i - last;
          if (i - last < min_gap) min_gap = i - last;
        end
        last = i;
        n++;
      end
      if (!busy) begin timed_out = 0; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick(); reset = 0;
    n_checks++;
    if ({coin_reject, no_funds, collect, motor_on, motor_lane, dispense, jam, half_out, credit, busy} !== 15'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h required 0", {coin_reject, no_funds, collect, motor_on,
               motor_lane, dispense, jam, half_out, credit, busy});
    end
  endtask

  task automatic test_exact_vend();
    int hits;
    coin(1, 0); coin(0, 1); coin(1, 0);
    n_checks++;
    if (credit !== 4'd4) begin n_errors++; $display("FAIL t1_credit: got %0d required 4", credit); end
    sel = 2'd1; sel_valid = 1; tick(); clear_inputs();
    n_checks++;
    if ({collect, motor_on, motor_lane, credit, busy} !== {1'b1, 1'b1, 2'd1, 4'd0, 1'b1}) begin
      n_errors++;
      $display("FAIL t1_collect: got c=%0d m=%0d l=%0d cr=%0d b=%0d required 1 1 1 0 1",
               collect, motor_on, motor_lane, credit, busy);
    end
    tick(); tick();
    n_checks++;
    if ({collect, motor_on} !== 2'b01) begin n_errors++; $display("FAIL t1_motor_hold: got %b required 01", {collect, motor_on}); end
    motor_done = 1; tick(); clear_inputs();
    n_checks++;
    if ({dispense, motor_on, busy} !== 3'b100) begin
      n_errors++; $display("FAIL t1_dispense: got %b required 100", {dispense, motor_on, busy});
    end
    hits = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (half_out) hits++; end
    n_checks++;
    if (hits !== 0) begin n_errors++; $display("FAIL t1_no_change: got %0d pulses required 0", hits); end
  endtask

  task automatic test_change_payout();
    int n, f, mx, mn; bit to;
    coin(0, 1); coin(0, 1); coin(0, 1);
    sel = 2'd0; sel_valid = 1; tick(); clear_inputs();
    n_checks++;
    if ({collect, credit} !== {1'b1, 4'd3}) begin n_errors++; $display("FAIL t2_collect: got c=%0d cr=%0d required 1 3", collect, credit); end
    motor_done = 1; tick(); clear_inputs();
    n_checks++;
    if ({dispense, busy, motor_on} !== 3'b110) begin n_errors++; $display("FAIL t2_dispense: got %b required 110", {dispense, busy, motor_on}); end
    drain(60, n, f, mx, mn, to);
    n_checks++;
    if ({to, 32'(n), 32'(f), 32'(mx), 32'(mn)} !== {1'b0, 32'd3, 32'd1, 32'd4, 32'd4}) begin
      n_errors++; $display("FAIL t2_pulses: got to=%0d n=%0d first=%0d gaps=%0d..%0d required 0 3 1 4..4", to, n, f, mn, mx);
    end
    n_checks++;
    if ({credit, busy} !== 5'd0) begin n_errors++; $display("FAIL t2_end: got cr=%0d b=%0d required 0 0", credit, busy); end
  endtask

  task automatic test_reject_and_funds();
    int n, f, mx, mn; bit to;
    coin(0, 1); coin(0, 1); coin(0, 1); coin(0, 1); coin(1, 0);
    coin(0, 1);
    n_checks++;
    if ({coin_reject, credit} !== {1'b1, 4'd9}) begin n_errors++; $display("FAIL t3_overflow: got rj=%0d cr=%0d required 1 9", coin_reject, credit); end
    coin(1, 0);
    n_checks++;
    if ({coin_reject, credit} !== {1'b0, 4'd10}) begin n_errors++; $display("FAIL t3_at_max: got rj=%0d cr=%0d required 0 10", coin_reject, credit); end
    coin(1, 0);
    n_checks++;
    if ({coin_reject, credit} !== {1'b1, 4'd10}) begin n_errors++; $display("FAIL t3_full: got rj=%0d cr=%0d required 1 10", coin_reject, credit); end
    cancel = 1; tick(); clear_inputs();
    drain(80, n, f, mx, mn, to);
    n_checks++;
    if ({to, 32'(n), credit} !== {1'b0, 32'd10, 4'd0}) begin n_errors++; $display("FAIL t3_refund: got to=%0d n=%0d cr=%0d required 0 10 0", to, n, credit); end
    coin(0, 1);
    sel = 2'd3; sel_valid = 1; tick(); clear_inputs();
    n_checks++;
    if ({no_funds, collect, credit, busy} !== {1'b1, 1'b0, 4'd2, 1'b0}) begin
      n_errors++; $display("FAIL t3_no_funds: got nf=%0d c=%0d cr=%0d b=%0d required 1 0 2 0", no_funds, collect, credit, busy);
    end
    sel = 2'd3; sel_valid = 1; half_dollar = 1; tick(); clear_inputs();
    n_checks++;
    if ({no_funds, coin_reject, credit} !== {1'b1, 1'b0, 4'd3}) begin
      n_errors++; $display("FAIL t3_refused_coin: got nf=%0d rj=%0d cr=%0d required 1 0 3", no_funds, coin_reject, credit);
    end
  endtask

  task automatic test_jam();
    int n, f, mx, mn, on_cycles, at; bit to;
    coin(0, 1);
    sel = 2'd2; sel_valid = 1; tick(); clear_inputs();
    n_checks++;
    if ({collect, motor_lane, credit} !== {1'b1, 2'd2, 4'd0}) begin n_errors++; $display("FAIL t4_collect: got c=%0d l=%0d cr=%0d required 1 2 0", collect, motor_lane, credit); end
    on_cycles = motor_on ? 1 : 0; at = -1;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (jam) begin at = i; break; end
      if (motor_on) on_cycles++;
    end
    n_checks++;
    if ({32'(at), 32'(on_cycles)} !== {32'd255, 32'd255}) begin n_errors++; $display("FAIL t4_jam_time: got at=%0d on=%0d required 255 255", at, on_cycles); end
    n_checks++;
    if ({motor_on, dispense, credit, busy} !== {1'b0, 1'b0, 4'd5, 1'b1}) begin
      n_errors++; $display("FAIL t4_refund_credit: got m=%0d d=%0d cr=%0d b=%0d required 0 0 5 1", motor_on, dispense, credit, busy);
    end
    drain(60, n, f, mx, mn, to);
    n_checks++;
    if ({to, 32'(n), credit} !== {1'b0, 32'd5, 4'd0}) begin n_errors++; $display("FAIL t4_payout: got to=%0d n=%0d cr=%0d required 0 5 0", to, n, credit); end
  endtask

  task automatic test_busy_coin_and_cancel();
    int n, f, mx, mn; bit to;
    cancel = 1; tick(); clear_inputs();
    n_checks++;
    if ({busy, half_out} !== 2'b00) begin n_errors++; $display("FAIL t5_cancel_zero: got %b required 00", {busy, half_out}); end
    coin(0, 1); coin(0, 1);
    sel = 2'd1; sel_valid = 1; tick(); clear_inputs();
    coin(1, 0);
    n_checks++;
    if ({coin_reject, credit, motor_on} !== {1'b1, 4'd0, 1'b1}) begin n_errors++; $display("FAIL t5_busy_coin: got rj=%0d cr=%0d m=%0d required 1 0 1", coin_reject, credit, motor_on); end
    motor_done = 1; tick(); clear_inputs();
    coin(0, 1); coin(0, 1);
    cancel = 1; sel_valid = 1; sel = 2'd0; tick(); clear_inputs();
    n_checks++;
    if ({collect, busy, motor_on, credit} !== {1'b0, 1'b1, 1'b0, 4'd4}) begin
      n_errors++; $display("FAIL t5_cancel_prio: got c=%0d b=%0d m=%0d cr=%0d required 0 1 0 4", collect, busy, motor_on, credit);
    end
    drain(60, n, f, mx, mn, to);
    n_checks++;
    if ({to, 32'(n), 32'(f)} !== {1'b0, 32'd4, 32'd1}) begin n_errors++; $display("FAIL t5_refund: got to=%0d n=%0d first=%0d required 0 4 1", to, n, f); end
  endtask

  task automatic test_reset_in_change();
    int hits;
    coin(0, 1); coin(0, 1); coin(1, 0);
    cancel = 1; tick(); clear_inputs();
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if ({credit, busy} !== {4'd3, 1'b1}) begin n_errors++; $display("FAIL t6_mid_change: got cr=%0d b=%0d required 3 1", credit, busy); end
    reset = 1; tick(); reset = 0;
    n_checks++;
    if ({coin_reject, no_funds, collect, motor_on, motor_lane, dispense, jam, half_out, credit, busy} !== 15'd0) begin
      n_errors++; $display("FAIL t6_reset_outputs: got %h required 0", {coin_reject, no_funds, collect, motor_on,
               motor_lane, dispense, jam, half_out, credit, busy});
    end
    hits = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (half_out || busy) hits++; end
    n_checks++;
    if (hits !== 0) begin n_errors++; $display("FAIL t6_no_payout: got %0d active cycles required 0", hits); end
  endtask

  initial begin
    test_reset();
    test_exact_vend();
    test_change_payout();
    test_reject_and_funds();
    test_jam();
    test_busy_coin_and_cancel();
    test_reset_in_change();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
